clk_div_mode_ctrl: RTL and testbench

// - Upstream stage of the 4:1 clock selector: derives four divided clocks from the board clock
//   (clk0..clk3 -> selector in0..in3) and drives selector lines sel0/sel1 from a mode push-button.
// - Each debounced button press advances the dog's speed mode 0->1->2->3->0.
// - Sits between board clock/button pins and the selector; the selector output paces the motion logic.

---
 rtl/clk_sel_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 100 ++++++++++
 rtl/clk_div_mode_ctrl.sv | 116 +++++++++++
 tb/tb_clk_div_mode_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// clk_sel_pkg
//   Shared definitions for the clock-selector front end.
//   - deb_state_e : button debounce FSM state encoding
//   - mode_t      : 2-bit speed-mode index {sel0, sel1}
//   - MODE_IN0..3 : mode values selecting selector inputs in0..in3
//   - next_mode() : mode advance with wrap 3 -> 0
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_e;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_IN0 = 2'd0;
  localparam mode_t MODE_IN1 = 2'd1;
  localparam mode_t MODE_IN2 = 2'd2;
  localparam mode_t MODE_IN3 = 2'd3;

  // Modulo-4 advance falls out of the 2-bit width.
  function automatic mode_t next_mode(input mode_t m);
    return m + MODE_IN1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchroniser followed by a four-state debounce FSM. A level
//   change is accepted only after DEB_CYCLES consecutive synchronised samples
//   at the new level; rise_o marks the edge on which a low->high change is
//   accepted.
// Ports
//   clk    in  board clock
//   rst_n  in  asynchronous active-low reset
//   btn_i  in  raw, bouncy, asynchronous button (active high)
//   rise_o out one-cycle advance request, valid for the upcoming clk edge
module btn_debounce
  import clk_sel_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // A single sample is enough: the WAIT states are never entered.
  localparam bit BYPASS = (DEB_CYCLES == 1);

  logic             sync1_q;
  logic             btn_s_q;
  deb_state_e       state_q;
  logic [CNT_W-1:0] dcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE_LOW;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= btn_i;
      btn_s_q <= sync1_q;
      case (state_q)
        IDLE_LOW: begin
          if (btn_s_q) begin
            if (BYPASS) begin
              state_q <= IDLE_HIGH;
            end else begin
              state_q <= WAIT_HIGH;
              dcnt_q  <= CNT_ONE;
            end
          end
        end
        WAIT_HIGH: begin
          if (!btn_s_q) begin
            state_q <= IDLE_LOW;
            dcnt_q  <= '0;
          end else if (dcnt_q == DEB_LAST) begin
            state_q <= IDLE_HIGH;
            dcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!btn_s_q) begin
            if (BYPASS) begin
              state_q <= IDLE_LOW;
            end else begin
              state_q <= WAIT_LOW;
              dcnt_q  <= CNT_ONE;
            end
          end
        end
        WAIT_LOW: begin
          if (btn_s_q) begin
            state_q <= IDLE_HIGH;
            dcnt_q  <= '0;
          end else if (dcnt_q == DEB_LAST) begin
            state_q <= IDLE_LOW;
            dcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          dcnt_q  <= '0;
        end
      endcase
    end
  end

  // Decoded from flops only (btn_s_q, state_q, dcnt_q), so there is no
  // combinational path from the pin. Kept unregistered so the mode register
  // in the parent updates on the same edge the FSM accepts the press.
  assign rise_o = btn_s_q &&
                  (((state_q == WAIT_HIGH) && (dcnt_q == DEB_LAST)) ||
                   (BYPASS && (state_q == IDLE_LOW)));

endmodule

// File: rtl/clk_div_mode_ctrl.sv
// clk_div_mode_ctrl
//   Front end of the 4:1 clock selector. Produces four free-running divided
//   clocks and a 2-bit speed mode that advances once per debounced press of
//   the mode button.
// Ports
//   clk        in  board clock, only clock domain
//   rst_n      in  asynchronous active-low reset
//   en         in  1 = dividers count, 0 = dividers hold
//   btn        in  raw mode button, active high
//   clk0..clk3 out divided clocks, half-period DIV0..DIV3 cycles
//   sel0       out mode bit 1 (MSB)
//   sel1       out mode bit 0 (LSB)
//   mode_pulse out one-cycle strobe when sel0/sel1 change
module clk_div_mode_ctrl
  import clk_sel_pkg::*;
#(
  parameter int DIV0       = 1,
  parameter int DIV1       = 2,
  parameter int DIV2       = 4,
  parameter int DIV3       = 8,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn,
  output logic clk0,
  output logic clk1,
  output logic clk2,
  output logic clk3,
  output logic sel0,
  output logic sel1,
  output logic mode_pulse
);

  logic [3:0] div_clk;

  // Dividers: identical counters that only differ in terminal count. They
  // share reset and enable, so they stay phase-aligned and are unaffected by
  // mode changes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_div
      localparam int DIV_G = (gi == 0) ? DIV0 :
                             (gi == 1) ? DIV1 :
                             (gi == 2) ? DIV2 : DIV3;
      localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_G - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] cnt_q;
      logic             clk_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          clk_q <= 1'b0;
        end else if (en) begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      end

      assign div_clk[gi] = clk_q;
    end
  endgenerate

  assign clk0 = div_clk[0];
  assign clk1 = div_clk[1];
  assign clk2 = div_clk[2];
  assign clk3 = div_clk[3];

  // Button path
  logic rise;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn),
    .rise_o (rise)
  );

  // Mode register
  mode_t mode_q;
  mode_t mode_d;
  logic  pulse_q;

  always_comb begin
    mode_d = mode_q;
    if (rise) begin
      mode_d = next_mode(mode_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_IN0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pulse_q <= rise;
    end
  end

  assign sel0       = mode_q[1];
  assign sel1       = mode_q[0];
  assign mode_pulse = pulse_q;

endmodule

// File: tb/tb_clk_div_mode_ctrl.sv
module tb_clk_div_mode_ctrl;

  localparam int DEB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic btn   = 1'b0;
  logic clk0, clk1, clk2, clk3, sel0, sel1, mode_pulse;

  int checks = 0;
  int errors = 0;

  clk_div_mode_ctrl #(
    .DIV0       (1),
    .DIV1       (2),
    .DIV2       (4),
    .DIV3       (8),
    .DEB_CYCLES (DEB),
    .CNT_W      (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .btn        (btn),
    .clk0       (clk0),
    .clk1       (clk1),
    .clk2       (clk2),
    .clk3       (clk3),
    .sel0       (sel0),
    .sel1       (sel1),
    .mode_pulse (mode_pulse)
  );

  always #5 clk = ~clk;

  logic [6:0] dut_vec;
  assign dut_vec = {clk3, clk2, clk1, clk0, sel0, sel1, mode_pulse};

  // Reference model: dividers from the number of enabled edges; button as
  // "accept a new level after DEB consecutive samples, advance on rising".
  longint en_edges;
  bit     b1, b2;      // btn sampled one and two edges ago
  bit     lvl;         // accepted button level
  int     run;         // consecutive samples disagreeing with lvl
  int     m_mode;
  bit     m_pulse;

  function automatic int div_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [3:0] c;
    logic [1:0] mm;
    for (int i = 0; i < 4; i++) c[i] = ((en_edges / div_of(i)) % 2) == 1;
    mm = 2'(m_mode);
    return {c, mm[1], mm[0], m_pulse};
  endfunction

  task automatic model_reset();
    en_edges = 0;
    b1 = 1'b0; b2 = 1'b0;
    lvl = 1'b0; run = 0;
    m_mode = 0; m_pulse = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then return 1 time unit later so outputs are sampled off the edge.
  task automatic step();
    bit s;
    @(posedge clk);
    if (en) en_edges++;
    s  = b2;
    b2 = b1;
    b1 = btn;
    m_pulse = 1'b0;
    if (s != lvl) begin
      run++;
      if (run == DEB) begin
        lvl = s;
        run = 0;
        if (s) begin
          m_mode  = (m_mode + 1) % 4;
          m_pulse = 1'b1;
        end
      end
    end else begin
      run = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", dut_vec, 7'b0);
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 7'b0) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", dut_vec, 7'b0);
    end
    $display("reset: outputs %b", dut_vec);
  endtask

  task automatic test_dividers();
    int first [4];
    int toggles [4];
    logic [3:0] prev;
    for (int i = 0; i < 4; i++) begin first[i] = 0; toggles[i] = 0; end
    prev = 4'b0;
    en = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL dividers edge %0d: got %b expected %b", e, dut_vec, exp_vec());
      end
      for (int i = 0; i < 4; i++) begin
        if (dut_vec[3+i] !== prev[i]) begin
          toggles[i]++;
          if (first[i] == 0) first[i] = e;
        end
      end
      prev = dut_vec[6:3];
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (first[i] != div_of(i) || toggles[i] != 64 / div_of(i)) begin
        errors++;
        $display("FAIL div%0d_timing: got first=%0d toggles=%0d expected first=%0d toggles=%0d",
                 i, first[i], toggles[i], div_of(i), 64 / div_of(i));
      end
      $display("divider %0d: first toggle edge %0d, %0d toggles in 64 edges", i, first[i], toggles[i]);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1;
    repeat (7) step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL en_hold cycle %0d: got %b expected %b", k, dut_vec, exp_vec());
      end
    end
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL en_resume cycle %0d: got %b expected %b", k, dut_vec, exp_vec());
      end
    end
    $display("enable: hold 10 / resume 20 done, outputs %b", dut_vec);
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int at = 0;
    btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b expected %b", e, dut_vec, exp_vec());
      end
      if (mode_pulse === 1'b1) begin pulses++; at = e; end
    end
    checks++;
    if (pulses != 1 || at != 6 || {sel0, sel1} !== 2'b01) begin
      errors++;
      $display("FAIL clean_press_summary: got pulses=%0d at=%0d sel=%b expected pulses=1 at=6 sel=01",
               pulses, at, {sel0, sel1});
    end
    btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL clean_release cycle %0d: got %b expected %b", k, dut_vec, exp_vec());
      end
    end
    $display("clean press: pulse at edge %0d, sel=%b", at, {sel0, sel1});
  endtask

  task automatic test_bounce();
    for (int len = 1; len <= 4; len++) begin
      int pulses = 0;
      logic [1:0] sel_before;
      sel_before = {sel0, sel1};
      btn = 1'b1;
      repeat (len) begin
        step();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL bounce len %0d high: got %b expected %b", len, dut_vec, exp_vec());
        end
        if (mode_pulse === 1'b1) pulses++;
      end
      btn = 1'b0;
      repeat (10) begin
        step();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL bounce len %0d low: got %b expected %b", len, dut_vec, exp_vec());
        end
        if (mode_pulse === 1'b1) pulses++;
      end
      checks++;
      if (pulses != ((len == DEB) ? 1 : 0) ||
          {sel0, sel1} !== ((len == DEB) ? sel_before + 2'd1 : sel_before)) begin
        errors++;
        $display("FAIL bounce_len%0d: got pulses=%0d sel=%b expected pulses=%0d from sel=%b",
                 len, pulses, {sel0, sel1}, (len == DEB) ? 1 : 0, sel_before);
      end
      $display("bounce: %0d-cycle glitch -> %0d pulse(s), sel=%b", len, pulses, {sel0, sel1});
    end
  endtask

  task automatic press_and_release(input string tag, output int pulses);
    pulses = 0;
    btn = 1'b1;
    repeat (9) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s high: got %b expected %b", tag, dut_vec, exp_vec());
      end
      if (mode_pulse === 1'b1) pulses++;
    end
    btn = 1'b0;
    repeat (9) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s low: got %b expected %b", tag, dut_vec, exp_vec());
      end
      if (mode_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [4];
    int p;
    exp_seq[0] = 2'b00; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b11;
    press_and_release("wrap_setup", p);
    checks++;
    if ({sel0, sel1} !== 2'b11) begin
      errors++;
      $display("FAIL wrap_setup: got sel=%b expected 11", {sel0, sel1});
    end
    for (int k = 0; k < 4; k++) begin
      press_and_release("wrap", p);
      checks++;
      if (p != 1 || {sel0, sel1} !== exp_seq[k]) begin
        errors++;
        $display("FAIL wrap_press%0d: got pulses=%0d sel=%b expected pulses=1 sel=%b",
                 k, p, {sel0, sel1}, exp_seq[k]);
      end
      $display("wrap: press %0d -> sel=%b pulses=%0d", k, {sel0, sel1}, p);
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    int at = 0;
    en = 1'b1;
    btn = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", dut_vec, 7'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_press edge %0d: got %b expected %b", e, dut_vec, exp_vec());
      end
      if (mode_pulse === 1'b1) begin pulses++; at = e; end
    end
    checks++;
    if (pulses != 1 || at != 6 || {sel0, sel1} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_press_summary: got pulses=%0d at=%0d sel=%b expected 1 at 6 sel=01",
               pulses, at, {sel0, sel1});
    end
    btn = 1'b0;
    repeat (8) step();
    $display("reset mid-press: re-press pulse at edge %0d, sel=%b", at, {sel0, sel1});
  endtask

  task automatic test_random();
    int hold = 0;
    int pulses = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        btn  = ~btn;
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      en = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", k, dut_vec, exp_vec());
      end
      if (mode_pulse === 1'b1) pulses++;
    end
    $display("random: 400 cycles, %0d mode pulses, final sel=%b", pulses, {sel0, sel1});
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dividers();
    test_enable_hold();
    en = 1'b0;
    test_clean_press();
    test_bounce();
    test_wrap();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
